// File: rtl/fp_add_arbiter_pkg.sv
// Shared types and default sizing for the floating-point adder arbiter.
package fp_add_arb_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_Z  = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

endpackage

// File: rtl/fp_add_arbiter_rr.sv
// Combinational round-robin picker: first requester after last_grant, with wrap-around.
import fp_add_arb_pkg::*;

module rr_arbiter #(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      last_grant,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      grant_idx,
  output logic            valid
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    // Offsets 1..NREQ walk from last_grant+1 round to last_grant itself.
    for (int unsigned k = 1; k <= NREQ; k++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!valid && req[j] && (j == (32'(last_grant) + k) % NREQ)) begin
          valid     = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = 3'(j);
        end
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one external floating-point adder among NREQ requesters.
import fp_add_arb_pkg::*;

module fp_add_arbiter #(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_stb,
  output logic [NREQ-1:0]   req_ack,
  output logic [W-1:0]      rsp_z,
  output logic [NREQ-1:0]   rsp_stb,
  input  logic [NREQ-1:0]   rsp_ack,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  output logic              add_a_stb,
  output logic              add_b_stb,
  input  logic              add_a_ack,
  input  logic              add_b_ack,
  input  logic [W-1:0]      add_z,
  input  logic              add_z_stb,
  output logic              add_z_ack,
  output logic              busy,
  output logic [2:0]        grant_id,
  output logic [15:0]       op_count
);

  arb_state_t      state;
  logic [2:0]      last_grant;
  logic [NREQ-1:0] rr_grant;
  logic [2:0]      rr_idx;
  logic            rr_valid;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            own_ack;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (req_stb),
    .last_grant (last_grant),
    .grant      (rr_grant),
    .grant_idx  (rr_idx),
    .valid      (rr_valid)
  );

  // Gated by rst so no accept is visible while reset is held.
  assign req_ack   = (state == IDLE && rst) ? rr_grant : '0;
  assign busy      = (state != IDLE);
  assign add_z_ack = (state == WAIT_Z);

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (rr_grant[j]) begin
        sel_a = req_a[j*W +: W];
        sel_b = req_b[j*W +: W];
      end
    end
  end

  always_comb begin
    rsp_stb = '0;
    if (state == RESPOND) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        rsp_stb[j] = (grant_id == 3'(j));
      end
    end
  end

  // Only the owner's acknowledge can close a response.
  assign own_ack = |(rsp_ack & rsp_stb);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 3'(NREQ - 1);
      grant_id   <= '0;
      add_a      <= '0;
      add_b      <= '0;
      add_a_stb  <= 1'b0;
      add_b_stb  <= 1'b0;
      rsp_z      <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rr_valid) begin
            add_a      <= sel_a;
            add_b      <= sel_b;
            grant_id   <= rr_idx;
            last_grant <= rr_idx;
            add_a_stb  <= 1'b1;
            add_b_stb  <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // Each operand strobe retires on its own handshake.
          if (add_a_stb && add_a_ack) add_a_stb <= 1'b0;
          if (add_b_stb && add_b_ack) add_b_stb <= 1'b0;
          if ((!add_a_stb || add_a_ack) && (!add_b_stb || add_b_ack)) begin
            state <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (add_z_stb) begin
            rsp_z <= add_z;
            state <= RESPOND;
          end
        end
        RESPOND: begin
          if (own_ack) begin
            op_count <= op_count + 16'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Randomised bench for fp_add_arbiter with a transaction-level reference model and adder model.
module tb_fp_add_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_stb = '0;
  logic [NREQ-1:0]   req_ack;
  logic [W-1:0]      rsp_z;
  logic [NREQ-1:0]   rsp_stb;
  logic [NREQ-1:0]   rsp_ack = '0;
  logic [W-1:0]      add_a, add_b;
  logic              add_a_stb, add_b_stb;
  logic              add_a_ack = 1'b0;
  logic              add_b_ack = 1'b0;
  logic [W-1:0]      add_z = '0;
  logic              add_z_stb = 1'b0;
  logic              add_z_ack;
  logic              busy;
  logic [2:0]        grant_id;
  logic [15:0]       op_count;

  fp_add_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
    .rsp_z(rsp_z), .rsp_stb(rsp_stb), .rsp_ack(rsp_ack),
    .add_a(add_a), .add_b(add_b), .add_a_stb(add_a_stb), .add_b_stb(add_b_stb),
    .add_a_ack(add_a_ack), .add_b_ack(add_b_ack),
    .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
    .busy(busy), .grant_id(grant_id), .op_count(op_count)
  );

  initial forever #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Float helpers through double precision; operands are small integers so sums are exact.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return '0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (last + k) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // Requester driver controls
  bit          eager   = 1'b0;
  bit          drop_en = 1'b0;
  int          remaining [NREQ];
  bit          pend      [NREQ];
  logic [31:0] op_a      [NREQ];
  logic [31:0] op_b      [NREQ];
  bit          use_fix   [NREQ];
  logic [31:0] fix_a     [NREQ];
  logic [31:0] fix_b     [NREQ];
  int          stall_left[NREQ];
  int          n_drop = 0;

  // Adder model controls
  int dA = 0, dB = 0, dZ = 0;
  bit rand_lat = 1'b0;
  bit spur_en  = 1'b0;

  // Reference model state and statistics
  bit          m_out = 1'b0, a_pend = 1'b0, b_pend = 1'b0, zw = 1'b0, rs = 1'b0;
  int          m_last = NREQ - 1;
  int          m_owner = 0;
  logic [31:0] m_a = '0, m_b = '0, m_sum = '0;
  int          m_count = 0;
  int          grant_log[$];
  logic [31:0] log_z[$];
  int          rsp1_high = 0;
  int          skew_cnt = 0;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      remaining[i] = 0; pend[i] = 1'b0; op_a[i] = '0; op_b[i] = '0;
      use_fix[i] = 1'b0; fix_a[i] = '0; fix_b[i] = '0; stall_left[i] = 0;
    end
  end

  // Requesters: hold req_stb until accepted, optionally withdraw, acknowledge results.
  initial begin : req_driver
    logic [NREQ-1:0] xfer;
    forever begin
      @(negedge clk);
      xfer = req_stb & req_ack;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (xfer[i]) pend[i] = 1'b0;
        if (pend[i] && drop_en && $urandom_range(0, 19) == 0) begin
          pend[i] = 1'b0;
          n_drop++;
        end else if (!pend[i] && remaining[i] > 0 && (eager || $urandom_range(0, 3) == 0)) begin
          if (use_fix[i]) begin
            op_a[i] = fix_a[i];
            op_b[i] = fix_b[i];
          end else begin
            op_a[i] = r2f(real'(int'($urandom_range(0, 4000)) - 2000));
            op_b[i] = r2f(real'(int'($urandom_range(0, 4000)) - 2000));
          end
          pend[i] = 1'b1;
          remaining[i]--;
        end
        req_a[i*W +: W] = op_a[i];
        req_b[i*W +: W] = op_b[i];
        req_stb[i] = pend[i];
        if (stall_left[i] > 0 && rsp_stb[i]) begin
          rsp_ack[i] = 1'b0;
          stall_left[i]--;
        end else begin
          rsp_ack[i] = ($urandom_range(0, 2) != 0);
        end
      end
    end
  end

  // Shared adder: acks operands after programmable delays, returns the sum, same reset.
  initial begin : adder_model
    bit got_a, got_b, spur, xa, xb, xz;
    int ca, cb, cz;
    logic [31:0] va, vb, sa, sb;
    got_a = 0; got_b = 0; spur = 0; ca = 0; cb = 0; cz = 0; va = '0; vb = '0;
    forever begin
      @(negedge clk);
      xa = add_a_stb && add_a_ack;
      xb = add_b_stb && add_b_ack;
      xz = add_z_stb && add_z_ack;
      sa = add_a;
      sb = add_b;
      @(posedge clk); #1;
      if (!rst) begin
        add_a_ack = 0; add_b_ack = 0; add_z_stb = 0; add_z = '0;
        got_a = 0; got_b = 0; spur = 0; ca = 0; cb = 0; cz = 0;
        continue;
      end
      if (spur) begin add_z_stb = 0; spur = 0; end
      if (xa) begin got_a = 1; va = sa; add_a_ack = 0; end
      if (xb) begin got_b = 1; vb = sb; add_b_ack = 0; end
      if (xz) begin
        add_z_stb = 0; got_a = 0; got_b = 0; ca = 0; cb = 0; cz = 0;
        if (rand_lat) begin
          dA = $urandom_range(0, 3); dB = $urandom_range(0, 3); dZ = $urandom_range(0, 4);
        end
      end
      if (add_a_stb && !got_a && !add_a_ack) begin
        if (ca >= dA) add_a_ack = 1; else ca++;
      end
      if (add_b_stb && !got_b && !add_b_ack) begin
        if (cb >= dB) add_b_ack = 1; else cb++;
      end
      if (got_a && got_b && !add_z_stb) begin
        if (cz >= dZ) begin add_z = fadd(va, vb); add_z_stb = 1; end
        else cz++;
      end else if (spur_en && !(got_a && got_b) && !add_z_stb && $urandom_range(0, 3) == 0) begin
        add_z = $urandom;
        add_z_stb = 1;
        spur = 1;
      end
    end
  end

  // Compare process: transaction-level expectations checked on every cycle.
  initial begin : compare
    int g;
    logic [NREQ-1:0] exp_ack, exp_rsp;
    bit na, nb;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rst_req_ack", req_ack, 0);
        check("rst_rsp_stb", rsp_stb, 0);
        check("rst_busy", busy, 0);
        check("rst_strobes", {add_a_stb, add_b_stb, add_z_ack}, 0);
        check("rst_data_a", {rsp_z, add_a}, 0);
        check("rst_data_b", {grant_id, op_count, add_b}, 0);
        m_out = 0; a_pend = 0; b_pend = 0; zw = 0; rs = 0;
        m_last = NREQ - 1; m_count = 0;
        continue;
      end
      g = m_out ? -1 : rr_pick(m_last, req_stb);
      exp_ack = (g < 0) ? '0 : (NREQ'(1) << g);
      check("req_ack", req_ack, exp_ack);
      check("busy", busy, m_out);
      if (m_out) check("grant_id", grant_id, m_owner);
      check("add_a_stb", add_a_stb, a_pend);
      check("add_b_stb", add_b_stb, b_pend);
      if (a_pend) check("add_a", add_a, m_a);
      if (b_pend) check("add_b", add_b, m_b);
      check("add_z_ack", add_z_ack, zw);
      exp_rsp = rs ? (NREQ'(1) << m_owner) : '0;
      check("rsp_stb", rsp_stb, exp_rsp);
      if (rs) check("rsp_z", rsp_z, m_sum);
      check("op_count", op_count, m_count & 16'hFFFF);
      if (rsp_stb[1]) rsp1_high++;
      if (add_b_stb && !add_a_stb) skew_cnt++;

      if (!m_out) begin
        if (g >= 0) begin
          m_out = 1; m_owner = g; m_last = g;
          m_a = req_a[g*W +: W]; m_b = req_b[g*W +: W];
          m_sum = fadd(m_a, m_b);
          a_pend = 1; b_pend = 1;
          grant_log.push_back(g);
        end
      end else if (a_pend || b_pend) begin
        na = a_pend && !add_a_ack;
        nb = b_pend && !add_b_ack;
        a_pend = na; b_pend = nb;
        if (!na && !nb) zw = 1;
      end else if (zw) begin
        if (add_z_stb) begin zw = 0; rs = 1; end
      end else if (rs) begin
        if (rsp_ack[m_owner]) begin
          log_z.push_back(rsp_z);
          rs = 0; m_out = 0; m_count++;
        end
      end
    end
  end

  task automatic wait_done(input string name);
    bit done;
    done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      done = !busy && !m_out;
      for (int i = 0; i < NREQ; i++) if (remaining[i] != 0 || pend[i]) done = 0;
    end
    check(name, done, 1);
  endtask

  task automatic set_rst(input logic v);
    @(posedge clk); #2;
    rst = v;
  endtask

  initial begin : main
    int base;
    bit found;
    // Reset held with all four requesting, then continuous contention.
    rst = 0;
    eager = 1;
    for (int i = 0; i < NREQ; i++) remaining[i] = 2;
    repeat (50) @(posedge clk);
    #2 rst = 1;
    wait_done("contention_done");
    eager = 0;
    check("grant0", grant_log.size() > 0 ? grant_log[0] : 99, 0);
    check("grant1", grant_log.size() > 1 ? grant_log[1] : 99, 1);
    check("grant2", grant_log.size() > 2 ? grant_log[2] : 99, 2);
    check("grant3", grant_log.size() > 3 ? grant_log[3] : 99, 3);
    check("grant4", grant_log.size() > 4 ? grant_log[4] : 99, 0);
    check("contention_count", op_count, 8);

    // Single op from requester 2: 1.0 + 2.0.
    set_rst(0);
    set_rst(1);
    use_fix[2] = 1; fix_a[2] = 32'h3F80_0000; fix_b[2] = 32'h4000_0000;
    base = log_z.size();
    remaining[2] = 1;
    wait_done("single_done");
    use_fix[2] = 0;
    check("single_rsp_z", log_z.size() > base ? log_z[base] : 32'hDEAD_BEEF, 32'h4040_0000);
    check("single_op_count", op_count, 1);

    // Requester 1 stalls its response while requester 3 waits.
    rsp1_high = 0;
    stall_left[1] = 20;
    remaining[1] = 1;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      found = busy;
    end
    check("stall_started", found, 1);
    remaining[3] = 1;
    wait_done("stall_done");
    check("stall_rsp1_held", rsp1_high >= 21, 1);
    check("stall_op_count", op_count, 3);

    // Adder acks operand b three cycles after operand a.
    dA = 0; dB = 3; dZ = 0;
    skew_cnt = 0;
    remaining[0] = 1;
    wait_done("skew_done");
    check("skew_cycles", skew_cnt, 3);
    dB = 0;

    // Reset while waiting on the adder result.
    dZ = 10;
    remaining[0] = 1;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      found = add_z_ack;
    end
    check("reached_wait_z", found, 1);
    set_rst(0);
    repeat (3) @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_rsp_stb", rsp_stb, 0);
    set_rst(1);
    dZ = 1;
    base = log_z.size();
    remaining[0] = 1;
    wait_done("after_rst_done");
    check("after_rst_op_count", op_count, 1);
    check("after_rst_responses", log_z.size() - base, 1);

    // Randomised traffic: latencies, withdrawals, spurious add_z_stb, noisy rsp_ack.
    rand_lat = 1; drop_en = 1; spur_en = 1;
    n_drop = 0;
    for (int i = 0; i < NREQ; i++) remaining[i] = 10;
    wait_done("random_done");
    check("random_op_count", op_count, 1 + 40 - n_drop);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
